diff_serial_tx: RTL and testbench

- Framed serial transmitter that drives an off-chip differential pair through an internal OBUFDS primitive.
- It is the transmit-side counterpart of the team's IBUFDS-based differential receive path.
- Accepts parallel words on a valid/ready handshake and serializes each word as start bit, data LSB first, optional parity bit and stop bit.
- The serial line is registered in fabric, then fed to OBUFDS (I = line register, O = tx_p, OB = tx_n).

---
 rtl/diff_serial_tx.sv | 180 ++++++++++++++++++
 tb/tb_diff_serial_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_serial_tx.sv
// Framed serial transmitter driving an off-chip differential pair.
// Each accepted word goes out as start bit, data LSB first, optional parity
// bit and stop bit. The serial line is a single register feeding the output
// buffer directly, so the pads switch only on clock edges and on reset.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, in_ready high, waiting for in_valid
// S_START  | line low for one bit time
// S_DATA   | line = shift[0], one bit time per data bit, LSB first
// S_PARITY | line = parity bit for one bit time (only when enabled)
// S_STOP   | line high for one bit time, then back to S_IDLE

// Behavioural stand-in for the vendor OBUFDS cell: o follows i, ob is its
// complement. Kept as its own module so the pad buffer is a distinct cell
// fed only by the line register.
module diff_serial_tx_obufds (
  input  logic i,
  output logic o,
  output logic ob
);

  assign o  = i;
  assign ob = ~i;

endmodule

module diff_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  tx_p,
  output logic                  tx_n
);

  // Counters are at least one bit wide so CLKS_PER_BIT = 1 and
  // DATA_WIDTH = 1 still elaborate to legal vectors.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  // Parity value 3 falls through as "no parity".
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state;
  logic                    line;
  logic [BW-1:0]           bit_cnt;
  logic [CW-1:0]           cyc_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    par_bit;

  logic                    bit_end;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   shift_next;

  // Bit boundary, handshake and next shift value.
  assign bit_end    = (cyc_cnt == CYC_LAST);
  assign accept     = in_valid && in_ready;
  assign shift_next = shift >> 1;

  // Frame sequencer: state, counters, shift register, line and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      line     <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          line    <= 1'b1;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (accept) begin
            shift    <= in_data;
            par_bit  <= (^in_data) ^ PAR_ODD;
            state    <= S_START;
            line     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end

        S_START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= S_DATA;
            line    <= shift[0];
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PAR_EN) begin
                state <= S_PARITY;
                line  <= par_bit;
              end else begin
                state <= S_STOP;
                line  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shift   <= shift_next;
              line    <= shift_next[0];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            state   <= S_STOP;
            line    <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end

        S_STOP: begin
          line <= 1'b1;
          if (bit_end) begin
            cyc_cnt  <= '0;
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          line     <= 1'b1;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cyc_cnt  <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  diff_serial_tx_obufds u_obufds (
    .i  (line),
    .o  (tx_p),
    .ob (tx_n)
  );

endmodule

// File: tb/tb_diff_serial_tx.sv
// Testbench for diff_serial_tx: four instances cover no/even/odd parity at
// four clocks per bit and no parity at one clock per bit.
`timescale 1ns/1ps

module tb_diff_serial_tx;

  localparam int NI = 4;
  localparam int CPB_P [NI] = '{4, 4, 4, 1};
  localparam int PAR_P [NI] = '{0, 1, 2, 0};

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_data [NI];
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] busy;
  logic [NI-1:0] tx_p;
  logic [NI-1:0] tx_n;

  int checks;
  int errors;

  bit exp_bits [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    diff_serial_tx #(
      .DATA_WIDTH   (8),
      .CLKS_PER_BIT (CPB_P[g]),
      .PARITY       (PAR_P[g])
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .busy     (busy[g]),
      .tx_p     (tx_p[g]),
      .tx_n     (tx_n[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame as a list of bit values, one entry per bit time.
  function automatic void build_frame(input logic [7:0] d, input int par);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      exp_bits.push_back(d[b]);
      if (d[b]) ones++;
    end
    if (par == 1) exp_bits.push_back((ones % 2) == 1);
    if (par == 2) exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = '1;
    for (int k = 0; k < NI; k++) in_data[k] = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tx_p !== 4'hF || tx_n !== 4'h0) begin
        errors++;
        $display("FAIL reset_pads cycle %0d tx_p=%b tx_n=%b expected 1111/0000", c, tx_p, tx_n);
      end
      checks++;
      if (in_ready !== 4'h0 || busy !== 4'h0) begin
        errors++;
        $display("FAIL reset_flags cycle %0d in_ready=%b busy=%b expected 0000/0000", c, in_ready, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_release in_ready=%b expected 1111", in_ready);
    end
    in_valid = '0;
  endtask

  // One frame on instance k; optionally in_data changes at frame cycle change_at.
  task automatic test_single_frame(input int k, input logic [7:0] d, input int change_at,
                                   input logic [7:0] nd, input string name);
    int cpb;
    int n;
    int waited;
    int busy_cnt;
    cpb = CPB_P[k];
    build_frame(d, PAR_P[k]);
    n = exp_bits.size() * cpb;
    waited = 0;
    while (in_ready[k] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout inst %0d in_ready=%b expected 1", name, k, in_ready[k]);
      return;
    end
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    @(negedge clk);
    in_valid[k] = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (i == change_at) in_data[k] = nd;
      checks++;
      if (tx_p[k] !== exp_bits[i / cpb]) begin
        errors++;
        $display("FAIL %s line inst %0d data %h cycle %0d tx_p=%b expected %b",
                 name, k, d, i, tx_p[k], exp_bits[i / cpb]);
      end
      checks++;
      if (tx_n[k] !== ~exp_bits[i / cpb]) begin
        errors++;
        $display("FAIL %s complement inst %0d cycle %0d tx_n=%b expected %b",
                 name, k, i, tx_n[k], ~exp_bits[i / cpb]);
      end
      checks++;
      if (in_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_in_frame inst %0d cycle %0d in_ready=%b expected 0", name, k, i, in_ready[k]);
      end
      if (busy[k] === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != n) begin
      errors++;
      $display("FAIL %s busy_len inst %0d busy cycles=%0d expected %0d", name, k, busy_cnt, n);
    end
    @(negedge clk);
    checks++;
    if (tx_p[k] !== 1'b1 || busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s post_idle inst %0d tx_p=%b busy=%b in_ready=%b expected 1/0/1",
               name, k, tx_p[k], busy[k], in_ready[k]);
    end
  endtask

  task automatic test_back_to_back();
    bit wave [$];
    int waited;
    wave.delete();
    build_frame(8'h00, 0);
    foreach (exp_bits[j]) wave.push_back(exp_bits[j]);
    wave.push_back(1'b1);
    build_frame(8'hFF, 0);
    foreach (exp_bits[j]) wave.push_back(exp_bits[j]);
    waited = 0;
    while (in_ready[3] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b ready_timeout in_ready=%b expected 1", in_ready[3]);
      return;
    end
    in_data[3]  = 8'h00;
    in_valid[3] = 1'b1;
    @(negedge clk);
    in_data[3] = 8'hFF;
    for (int i = 0; i < wave.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i == 11) in_valid[3] = 1'b0;
      checks++;
      if (tx_p[3] !== wave[i] || tx_n[3] !== ~wave[i]) begin
        errors++;
        $display("FAIL b2b line cycle %0d tx_p=%b tx_n=%b expected %b/%b", i, tx_p[3], tx_n[3], wave[i], ~wave[i]);
      end
      checks++;
      if (in_ready[3] !== (i == 10)) begin
        errors++;
        $display("FAIL b2b ready cycle %0d in_ready=%b expected %b", i, in_ready[3], (i == 10));
      end
      checks++;
      if (busy[3] !== (i != 10)) begin
        errors++;
        $display("FAIL b2b busy cycle %0d busy=%b expected %b", i, busy[3], (i != 10));
      end
    end
    @(negedge clk);
    checks++;
    if (tx_p[3] !== 1'b1 || busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b final_idle tx_p=%b busy=%b expected 1/0", tx_p[3], busy[3]);
    end
  endtask

  task automatic test_reset_midframe();
    int waited;
    waited = 0;
    while (in_ready[1:0] !== 2'b11 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (in_ready[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL midrst ready_timeout in_ready=%b expected 11", in_ready[1:0]);
      return;
    end
    in_data[0]    = 8'h0F;
    in_data[1]    = 8'h00;
    in_valid[1:0] = 2'b11;
    @(negedge clk);
    in_valid[1:0] = 2'b00;
    repeat (16) @(negedge clk);
    // Frame cycle 16 is the first cycle of data bit 3 at four clocks per bit.
    checks++;
    if (tx_p[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL midrst pre_reset tx_p=%b expected 01", tx_p[1:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_p[1:0] !== 2'b11 || tx_n[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL midrst async_line tx_p=%b tx_n=%b expected 11/00", tx_p[1:0], tx_n[1:0]);
    end
    checks++;
    if (busy[1:0] !== 2'b00 || in_ready[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL midrst async_flags busy=%b in_ready=%b expected 00/00", busy[1:0], in_ready[1:0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (tx_p !== 4'hF || busy !== 4'h0 || in_ready !== 4'hF) begin
        errors++;
        $display("FAIL midrst residual cycle %0d tx_p=%b busy=%b in_ready=%b expected 1111/0000/1111",
                 c, tx_p, busy, in_ready);
      end
    end
    test_single_frame(0, 8'h3C, -1, 8'h00, "after_reset");
  endtask

  task automatic test_random();
    int k;
    logic [7:0] d;
    for (int t = 0; t < 16; t++) begin
      k = $urandom_range(0, NI - 1);
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_single_frame(k, d, -1, 8'h00, "random");
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    in_valid = '0;
    for (int k = 0; k < NI; k++) in_data[k] = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_single_frame(0, 8'hA5, -1, 8'h00, "basic_a5");
    test_single_frame(1, 8'hA5, -1, 8'h00, "even_parity_a5");
    test_single_frame(2, 8'hA5, -1, 8'h00, "odd_parity_a5");
    test_back_to_back();
    test_reset_midframe();
    test_single_frame(0, 8'h55, 3 * CPB_P[0], 8'hAA, "data_change");
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
